// File: rtl/tube_scan_driver.sv
// -----------------------------------------------------------------------------
// tube_scan_driver
//
// Time-multiplexed scan driver for a multi-digit 7-segment display. A
// 4*DIGITS-bit hex value is shown one nibble at a time. Each digit stays lit
// for DIV clock cycles, and a full frame lasts DIV*DIGITS cycles. New values
// enter through a load/ready handshake into a shadow register. They are
// copied to the displayed register only at the end of a frame, so a frame
// never mixes two values.
//
// Parameters:
//   DIGITS     number of digits (1..8)
//   DIV        clock cycles each digit stays lit (>= 1)
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous, active-high reset
//   load       request to capture data (honoured only while ready = 1)
//   data       value to display; nibble i is shown on digit i
//   ready      shadow register empty; a load is accepted this cycle
//   x          nibble of the digit currently lit (to the decoder x[3:0])
//   an         active-low one-hot digit enable
//   frame_done one-cycle pulse on the last cycle of each frame
//
// Optional feature (compile-time macro TUBE_BLANK_LEADING_ZERO_EN):
//   When defined, digits above the most significant nonzero nibble are kept
//   dark (an all ones). Digit 0 is always lit. The scan timing and x are
//   not affected.
// -----------------------------------------------------------------------------
module tube_scan_driver #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    output logic                  ready,
    output logic [3:0]            x,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                pending_q, pending_d;

    logic tick;
    logic wrap;

    // With DIV=1 the counter is a single bit held at 0, so tick stays high.
    assign tick = (cnt_q == CNT_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A commit needs pending=1, so ready is low and a load in the same
        // cycle is ignored. When nothing is pending, a load on the wrap
        // cycle is captured and commits at the following wrap.
        if (wrap && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (load && !pending_q) begin
            shadow_d  = data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign ready      = !pending_q;
    assign frame_done = wrap;

    // Nibble select and one-hot enable. The loops avoid a variable part-select
    // that could address past the register for non-power-of-two DIGITS.
    always_comb begin
        x = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                x = disp_q[4*i +: 4];
            end
        end
    end

`ifdef TUBE_BLANK_LEADING_ZERO_EN
    logic [IDX_W-1:0] msd;

    // Index of the most significant nonzero nibble. It stays 0 for an
    // all-zero value, which keeps digit 0 lit.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
    end

    always_comb begin
        an = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                an[i] = 1'b0;
            end
        end
        if (idx_q > msd) begin
            an = '1;
        end
    end
`else
    always_comb begin
        an = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                an[i] = 1'b0;
            end
        end
    end
`endif

endmodule
